ram_wr_ctrl: RTL and testbench

- Upstream control stage for the 16x8 register-file RAM.
- Turns a raw push-button and the switch bank into clean, single-cycle RAM write strobes at an auto-incrementing address.
- Provides a scan mode that steps the RAM read address through all locations on a timer, so the downstream 7-segment decoders show each stored byte in turn.
- Drives the RAM we/addr/din inputs directly.

---
 rtl/ram_ctrl_pkg.sv | 17 +
 rtl/ram_wr_ctrl_if.sv | 26 ++
 rtl/ram_wr_ctrl_key_debounce.sv | 50 +++++
 rtl/ram_wr_ctrl.sv | 127 ++++++++++++
 tb/tb_ram_wr_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM write/scan controller.
// The *_SIM values shrink the debounce and scan timers so simulations stay short.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SCAN
    } state_t;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;

    localparam logic [19:0] DEB_CYCLES_SIM  = 20'd4;
    localparam logic [25:0] SCAN_CYCLES_SIM = 26'd8;

endpackage

// File: rtl/ram_wr_ctrl_if.sv
// User-input and RAM-port bundle of the write controller.
// The master side is the controller; the slave side is the board/RAM side.
interface ram_wr_if
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    logic              key_n;
    logic              mode;
    logic [DATA_W-1:0] sw_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              full;

    modport master (
        input  key_n, mode, sw_data,
        output ram_we, ram_addr, ram_din, full
    );

    modport slave (
        output key_n, mode, sw_data,
        input  ram_we, ram_addr, ram_din, full
    );
endinterface

// File: rtl/ram_wr_ctrl_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on each debounced 1->0 transition.
module key_debounce #(
    parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press,
    output logic level
);

    logic        key_p0;
    logic        key_p1;
    logic        level_d;
    logic [19:0] cnt;

    // synchronizer stage boundary: raw pin -> key_p0 -> key_p1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
        end
    end

    // Any return to agreement restarts the count, so short glitches never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            level   <= 1'b1;
            level_d <= 1'b1;
        end else begin
            level_d <= level;
            if (key_p1 == level) begin
                cnt <= '0;
            end else if (cnt == DEB_CYCLES) begin
                level <= key_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

    assign press = level_d & ~level;

endmodule

// File: rtl/ram_wr_ctrl.sv
// RAM write controller: debounced key presses write sw_data at an
// auto-incrementing address; scan mode steps the read address on a timer.
module ram_wr_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter logic [19:0] DEB_CYCLES  = 20'd500000,
    parameter logic [25:0] SCAN_CYCLES = 26'd25000000,
    parameter int          ADDR_W      = RAM_ADDR_W,
    parameter int          DATA_W      = RAM_DATA_W
) (
    input  logic     clk,
    input  logic     rst_n,
    ram_wr_if.master bus
);

    state_t            state, state_nxt;
    logic              mode_p0, mode_p1;
    logic              press, key_level, press_evt;

    logic              we_q, we_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] din_q, din_nxt;
    logic              full_q, full_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W-1:0] scan_ptr, scan_ptr_nxt;
    logic [25:0]       timer, timer_nxt;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.key_n),
        .press (press),
        .level (key_level)
    );

    assign press_evt = press & ~key_level;

    // synchronizer stage boundary: raw mode switch -> mode_p0 -> mode_p1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_p0 <= 1'b0;
            mode_p1 <= 1'b0;
        end else begin
            mode_p0 <= bus.mode;
            mode_p1 <= mode_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Mode is checked before the press so a coincident press is dropped.
    always_comb begin
        state_nxt    = state;
        we_nxt       = 1'b0;
        addr_nxt     = addr_q;
        din_nxt      = din_q;
        full_nxt     = full_q;
        wr_ptr_nxt   = wr_ptr;
        scan_ptr_nxt = scan_ptr;
        timer_nxt    = timer;
        unique case (state)
            IDLE: begin
                if (mode_p1) begin
                    scan_ptr_nxt = '0;
                    timer_nxt    = '0;
                    addr_nxt     = '0;
                    state_nxt    = SCAN;
                end else if (press_evt) begin
                    din_nxt   = bus.sw_data;
                    addr_nxt  = wr_ptr;
                    we_nxt    = 1'b1;
                    state_nxt = WRITE;
                end else begin
                    addr_nxt = wr_ptr;
                end
            end
            WRITE: begin
                wr_ptr_nxt = wr_ptr + 1'b1;
                if (wr_ptr == {ADDR_W{1'b1}}) full_nxt = 1'b1;
                state_nxt = IDLE;
            end
            SCAN: begin
                if (!mode_p1) begin
                    state_nxt = IDLE;
                end else if (timer == SCAN_CYCLES - 26'd1) begin
                    timer_nxt    = '0;
                    scan_ptr_nxt = scan_ptr + 1'b1;
                    addr_nxt     = scan_ptr + 1'b1;
                end else begin
                    timer_nxt = timer + 26'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            full_q   <= 1'b0;
            wr_ptr   <= '0;
            scan_ptr <= '0;
            timer    <= '0;
        end else begin
            we_q     <= we_nxt;
            addr_q   <= addr_nxt;
            din_q    <= din_nxt;
            full_q   <= full_nxt;
            wr_ptr   <= wr_ptr_nxt;
            scan_ptr <= scan_ptr_nxt;
            timer    <= timer_nxt;
        end
    end

    assign bus.ram_we   = we_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_din  = din_q;
    assign bus.full     = full_q;

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Self-checking bench for ram_wr_ctrl with shortened debounce/scan timers.
// Expected writes come from a simple press-count model of the address sequence.
module tb_ram_wr_ctrl;
    import ram_ctrl_pkg::*;

    localparam int DEB  = int'(DEB_CYCLES_SIM);
    localparam int SCAN = int'(SCAN_CYCLES_SIM);
    localparam int NLOC = 16;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
        logic       full;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_wr_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_wr_ctrl #(
        .DEB_CYCLES  (DEB_CYCLES_SIM),
        .SCAN_CYCLES (SCAN_CYCLES_SIM),
        .ADDR_W      (4),
        .DATA_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wr_t  act_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   last_wr_cyc = -1;
    int   full_rise = -1;
    logic we_prev = 1'b0;
    logic full_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed write strobes, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.ram_we === 1'b1) begin
            checks++;
            assert (we_prev === 1'b0) else begin
                errors++;
                $error("FAIL we_pulse_width obs=%0b exp=0 cyc=%0d", we_prev, cyc);
            end
            act_q.push_back('{bus.ram_addr, bus.ram_din, cyc, bus.full});
        end
        if (bus.full === 1'b1 && full_prev !== 1'b1) full_rise = cyc;
        we_prev   = bus.ram_we;
        full_prev = bus.full;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.key_n   = 1'b1;
        bus.mode    = 1'b0;
        repeat (2) @(negedge clk);
        act_q.delete();
        model_cnt   = 0;
        full_rise   = -1;
        rst_n       = 1'b1;
    endtask

    task automatic do_press(input logic [7:0] d, input int hold);
        int  k;
        wr_t w;
        @(negedge clk);
        bus.sw_data = d;
        bus.key_n   = 1'b0;
        k = cyc + 1;
        repeat (hold) @(negedge clk);
        bus.key_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("wr_count", 32'(act_q.size()), 32'd1);
        if (act_q.size() > 0) begin
            w = act_q.pop_front();
            chk("wr_addr", 32'(w.addr), 32'(model_cnt % NLOC));
            chk("wr_data", 32'(w.data), 32'(d));
            chk("wr_latency", 32'(w.cyc), 32'(k + DEB + 3));
            chk("full_at_wr", 32'(w.full), 32'(model_cnt >= NLOC));
            last_wr_cyc = w.cyc;
            model_cnt++;
        end
        act_q.delete();
        chk("addr_after", 32'(bus.ram_addr), 32'(model_cnt % NLOC));
        chk("full_after", 32'(bus.full), 32'(model_cnt >= NLOC));
    endtask

    task automatic do_glitch(input int g);
        @(negedge clk);
        bus.key_n = 1'b0;
        repeat (g) @(negedge clk);
        bus.key_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("glitch_no_wr", 32'(act_q.size()), 32'd0);
        act_q.delete();
        chk("glitch_addr", 32'(bus.ram_addr), 32'(model_cnt % NLOC));
    endtask

    initial begin
        int   c;
        logic seen;

        rst_n       = 1'b0;
        bus.key_n   = 1'b1;
        bus.mode    = 1'b0;
        bus.sw_data = 8'h00;

        // Reset values, then an idle stretch in write mode
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(bus.ram_we), 32'd0);
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_din", 32'(bus.ram_din), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_no_wr", 32'(act_q.size()), 32'd0);
        chk("idle_addr", 32'(bus.ram_addr), 32'd0);
        chk("idle_din", 32'(bus.ram_din), 32'd0);
        chk("idle_full", 32'(bus.full), 32'd0);

        // Three clean presses
        do_press(8'h12, 10);
        do_press(8'h34, 10);
        do_press(8'h56, 10);
        chk("addr_after_3", 32'(bus.ram_addr), 32'd3);

        // Bounce shorter than the debounce window, then a clean press
        do_glitch(3);
        do_press(8'($urandom), 10);

        // Seventeen presses: full after the sixteenth, address wraps to 0
        do_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            do_press(8'(i), $urandom_range(5, 12));
            if (i == 15) chk("full_rise_cyc", 32'(full_rise), 32'(last_wr_cyc + 1));
        end
        chk("full_sticky", 32'(bus.full), 32'd1);

        // Scan mode after two writes, with presses that must be ignored
        do_reset();
        repeat (3) @(negedge clk);
        do_press(8'($urandom), 8);
        do_press(8'($urandom), 8);
        @(negedge clk);
        bus.mode = 1'b1;
        c = cyc;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            chk("scan_addr", 32'(bus.ram_addr),
                (cyc >= c + 3) ? 32'(((cyc - (c + 3)) / SCAN) % NLOC) : 32'd2);
            bus.key_n = (i < 130 && ((i / 10) % 2) == 0) ? 1'b0 : 1'b1;
        end
        chk("scan_no_wr", 32'(act_q.size()), 32'd0);
        bus.mode = 1'b0;
        repeat (6) @(negedge clk);
        chk("scan_exit_addr", 32'(bus.ram_addr), 32'd2);
        chk("scan_exit_no_wr", 32'(act_q.size()), 32'd0);
        do_press(8'($urandom), 9);

        // Random mix of presses and short bounces
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) do_glitch($urandom_range(1, 3));
            else                           do_press(8'($urandom), $urandom_range(5, 12));
        end

        // Reset asserted during the write-strobe cycle
        @(negedge clk);
        bus.sw_data = 8'($urandom);
        bus.key_n   = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.ram_we === 1'b1) seen = 1'b1;
        end
        chk("mid_we_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_we_async_clr", 32'(bus.ram_we), 32'd0);
        bus.key_n = 1'b1;
        repeat (2) @(negedge clk);
        act_q.delete();
        model_cnt = 0;
        full_rise = -1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("post_rst_full", 32'(bus.full), 32'd0);
        chk("post_rst_no_wr", 32'(act_q.size()), 32'd0);
        do_press(8'($urandom), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
